uart_tx_serializer: RTL and testbench
=====================================

// Module: uart_tx_serializer
// PURPOSE
//  UART transmit engine: takes a parallel byte via valid/ready, serializes it LSB-first onto
//  tx_line as start + DATA_WIDTH data + optional parity + 1/2 stop bits, at a selectable baud rate.
//  Counterpart to the UART-Rx path (same baud_rate encoding, same frame format); sits between
//  the host/register interface and the chip's TX pad.
// PARAMETERS
//  CLK_FREQ    50_000_000  system clock frequency in Hz; sets bit-period divisors
//  DATA_WIDTH  8           data bits per frame
// PORTS
//  clock        in   1           system clock, rising edge
//  reset        in   1           asynchronous, active-high reset
//  baud_rate    in   2           00=2400 01=4800 10=9600 11=19200; sampled on accept
//  parity_type  in   2           00=none 01=odd 10=even 11=none; sampled on accept
//  stop_bits    in   1           0=one stop bit, 1=two; sampled on accept
//  tx_data      in   DATA_WIDTH  byte to send; sampled on accept
//  tx_valid     in   1           host offers tx_data
//  tx_ready     out  1           engine can accept; accept = tx_valid & tx_ready at rising edge
//  tx_line      out  1           serial output, idle high
//  tx_busy      out  1           frame in progress (START..STOP)
//  tx_done      out  1           1-cycle pulse in the last cycle of the final stop bit
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, tx_line=1, tx_ready=1, tx_busy=0, tx_done=0, counters=0.
//  Bit period DIV = CLK_FREQ/baud, rounded to nearest: 20833 / 10417 / 5208 / 2604 at 50 MHz.
//  FSM: IDLE -> START -> DATA (DATA_WIDTH bits) -> PARITY (if enabled & type 01/10) -> STOP (1 or 2 bits) -> IDLE.
//  Accept at edge k: tx_data, baud_rate, parity_type, stop_bits latched; tx_line=0 from edge k+1;
//   tx_ready=0, tx_busy=1 from edge k+1. Baud counter restarts at accept: every bit is exactly DIV cycles.
//  DATA: LSB first, bit index 0..DATA_WIDTH-1 wraps to parity/stop, never reused.
//  Parity bit: even => XOR of data bits; odd => inverted XOR.
//  STOP: tx_line=1; tx_done=1 in final cycle of last stop bit; next edge: IDLE, tx_ready=1, tx_busy=0.
//  Frame length = (1+DATA_WIDTH+P+S)*DIV cycles from tx_line fall to tx_ready rise (P in {0,1}, S in {1,2}).
//  Back-to-back: a tx_valid held high is accepted in the first IDLE cycle; minimum one idle-high cycle between frames.
//  Input changes while busy (baud_rate, parity_type, stop_bits, tx_data) have no effect on the current frame.
//  tx_valid while busy: ignored, not queued; host must hold tx_valid until tx_ready.
//  Reset mid-frame: tx_line returns to 1 immediately (asynchronously), frame discarded, no tx_done.
//  tx_line, tx_ready, tx_busy, tx_done are registered outputs (glitch-free pad drive).
// CONFIGURATION
//  UART_TX_PARITY_EN defined: PARITY state present, parity_type honoured as above.
//  Undefined: PARITY state and parity logic removed; parity_type ignored; frames never carry parity (P=0).
// STRUCTURE
//  Package uart_pkg: baud-select encodings, parity-type encodings, DIV constants per baud (from CLK_FREQ),
//   TX state enum {IDLE, START, DATA, PARITY, STOP}.
//  Sub-module uart_tx_baud_gen: 1x bit-period tick generator; inputs clock, reset, restart, divisor;
//   output tick high 1 cycle every DIV cycles, counter cleared on restart.
//  Top: FSM, shift register, bit counter, stop counter, parity accumulator.
// TESTING
//  1 Reset: assert reset mid-frame -> tx_line=1 same cycle, tx_ready=1, tx_busy=0, no tx_done after release.
//  2 baud=11, no parity, 1 stop, tx_data=0x55 -> line 0,1,0,1,0,1,0,1,0,1 each 2604 cycles; tx_done at cycle 26040.
//  3 baud=10, even parity, tx_data=0x07 -> parity bit 1, 11-bit frame, 57288 cycles; odd parity -> bit 0.
//  4 stop_bits=1, baud=00, tx_data=0xA3 -> two stop bits, tx_ready rises 11*20833=229163 cycles after line falls.
//  5 tx_valid held high, bytes 0x11,0x22 -> second start bit exactly one idle cycle after first frame ends.
//  6 baud_rate changed 11->00 mid-frame -> current frame keeps DIV=2604; next frame uses 20833.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART encodings, state enum and bit-period divisor helpers.
// Divisors round CLK_FREQ/baud to the nearest integer.
package uart_pkg;

  localparam int unsigned DEF_CLK_FREQ = 50_000_000;
  localparam int DIV_W = 24;

  localparam logic [1:0] BAUD_2400  = 2'b00;
  localparam logic [1:0] BAUD_4800  = 2'b01;
  localparam logic [1:0] BAUD_9600  = 2'b10;
  localparam logic [1:0] BAUD_19200 = 2'b11;

  localparam logic [1:0] PAR_NONE  = 2'b00;
  localparam logic [1:0] PAR_ODD   = 2'b01;
  localparam logic [1:0] PAR_EVEN  = 2'b10;
  localparam logic [1:0] PAR_NONE3 = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  function automatic int unsigned baud_of(input logic [1:0] sel);
    int unsigned b;
    case (sel)
      BAUD_2400: b = 2400;
      BAUD_4800: b = 4800;
      BAUD_9600: b = 9600;
      default:   b = 19200;
    endcase
    return b;
  endfunction

  function automatic logic [DIV_W-1:0] div_for(
    input int unsigned clk_freq,
    input logic [1:0]  sel
  );
    int unsigned b;
    b = baud_of(sel);
    return DIV_W'((clk_freq + b / 2) / b);
  endfunction

  localparam logic [DIV_W-1:0] DIV_2400  =
    div_for(DEF_CLK_FREQ, BAUD_2400);
  localparam logic [DIV_W-1:0] DIV_4800  =
    div_for(DEF_CLK_FREQ, BAUD_4800);
  localparam logic [DIV_W-1:0] DIV_9600  =
    div_for(DEF_CLK_FREQ, BAUD_9600);
  localparam logic [DIV_W-1:0] DIV_19200 =
    div_for(DEF_CLK_FREQ, BAUD_19200);

endpackage

// File: rtl/uart_tx_baud_gen.sv
// uart_tx_baud_gen: bit-period tick, high in the last cycle of every divisor period.
// tick_next flags the cycle before tick so callers can register on it.
module uart_tx_baud_gen
  import uart_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             restart,
  input  logic [DIV_W-1:0] divisor,
  output logic             tick,
  output logic             tick_next
);

  logic [DIV_W-1:0] cnt;

  assign tick_next = (cnt == divisor - DIV_W'(2));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (restart) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= (cnt >= divisor - DIV_W'(1)) ? '0 : cnt + DIV_W'(1);
      tick <= tick_next;
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: UART transmit engine, start + data LSB-first + parity + stop.
// Define UART_TX_PARITY_EN to build the PARITY state and honour parity_type.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int          DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            baud_rate,
  input  logic [1:0]            parity_type,
  input  logic                  stop_bits,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx_line,
  output logic                  tx_busy,
  output logic                  tx_done
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  localparam logic [DIV_W-1:0] DIV_B0 = div_for(CLK_FREQ, BAUD_2400);
  localparam logic [DIV_W-1:0] DIV_B1 = div_for(CLK_FREQ, BAUD_4800);
  localparam logic [DIV_W-1:0] DIV_B2 = div_for(CLK_FREQ, BAUD_9600);
  localparam logic [DIV_W-1:0] DIV_B3 = div_for(CLK_FREQ, BAUD_19200);

  tx_state_t             state, state_n;
  logic [DATA_WIDTH-1:0] sh, sh_n;
  logic [BW-1:0]         bit_cnt;
  logic                  stop_cnt;
  logic [1:0]            baud_q;
  logic                  two_stop_q;
  logic [DIV_W-1:0]      divisor;
  logic                  accept, tick, tick_next;
  logic                  last_stop;
  logic                  par_en, par_bit;
  logic                  line_d, done_d;

  assign accept    = tx_valid && tx_ready;
  assign last_stop = (stop_cnt == two_stop_q);

  always_comb begin
    divisor = DIV_B0;
    case (baud_q)
      BAUD_4800:  divisor = DIV_B1;
      BAUD_9600:  divisor = DIV_B2;
      BAUD_19200: divisor = DIV_B3;
      default:    divisor = DIV_B0;
    endcase
  end

  uart_tx_baud_gen u_baud (
    .clock     (clock),
    .reset     (reset),
    .restart   (accept),
    .divisor   (divisor),
    .tick      (tick),
    .tick_next (tick_next)
  );

`ifdef UART_TX_PARITY_EN
  logic par_en_q, par_q;

  // Seed with 1 for odd so the final XOR lands on the inverted sum
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
    end else if (accept) begin
      par_en_q <= (parity_type == PAR_ODD) ||
                  (parity_type == PAR_EVEN);
      par_q    <= (parity_type == PAR_ODD);
    end else if (state == DATA && tick) begin
      par_q <= par_q ^ sh[0];
    end
  end

  assign par_en  = par_en_q;
  assign par_bit = par_q ^ sh[0];
`else
  logic unused_parity;
  assign unused_parity = ^parity_type;
  assign par_en        = 1'b0;
  assign par_bit       = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      sh         <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      baud_q     <= BAUD_2400;
      two_stop_q <= 1'b0;
      tx_line    <= 1'b1;
      tx_ready   <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      state    <= state_n;
      sh       <= sh_n;
      tx_line  <= line_d;
      tx_ready <= (state_n == IDLE);
      tx_busy  <= (state_n != IDLE);
      tx_done  <= done_d;
      if (accept) begin
        baud_q     <= baud_rate;
        two_stop_q <= stop_bits;
        bit_cnt    <= '0;
        stop_cnt   <= 1'b0;
      end else begin
        if (state == DATA && tick)
          bit_cnt <= bit_cnt + BW'(1);
        if (state == STOP && tick)
          stop_cnt <= 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:   if (accept) state_n = START;
      START:  if (tick) state_n = DATA;
      DATA:
        if (tick && bit_cnt == LAST_BIT)
          state_n = par_en ? PARITY : STOP;
      PARITY: if (tick) state_n = STOP;
      STOP:   if (tick && last_stop) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are computed one cycle ahead and registered
  always_comb begin
    sh_n = sh;
    if (accept)
      sh_n = tx_data;
    else if (state == DATA && tick)
      sh_n = sh >> 1;
    line_d = 1'b1;
    case (state_n)
      IDLE:    line_d = 1'b1;
      START:   line_d = 1'b0;
      DATA:    line_d = sh_n[0];
      PARITY:  line_d = (state == DATA) ? par_bit : tx_line;
      STOP:    line_d = 1'b1;
      default: line_d = 1'b1;
    endcase
    done_d = (state == STOP) && last_stop && tick_next;
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: directed frame checks at a reduced clock rate.
// Divisors at 200 kHz: 2400->83, 4800->42, 9600->21, 19200->10.
module tb_uart_tx_serializer;

  localparam int unsigned CLK_FREQ = 200_000;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] baud_rate = 2'b00;
  logic [1:0] parity_type = 2'b00;
  logic       stop_bits = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_line, tx_busy, tx_done;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  uart_tx_serializer #(
    .CLK_FREQ   (CLK_FREQ),
    .DATA_WIDTH (8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .baud_rate   (baud_rate),
    .parity_type (parity_type),
    .stop_bits   (stop_bits),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_line     (tx_line),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic accept_frame(
    input string      nm,
    input logic [7:0] d,
    input logic [1:0] br,
    input logic [1:0] pt,
    input logic       sb,
    input logic       hold,
    input logic       scramble
  );
    int i;
    i = 0;
    while (tx_ready !== 1'b1 && i < 2000) begin
      step();
      i++;
    end
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready: tx_ready=%b, required 1 within 2000 cycles",
               nm, tx_ready);
    end
    tx_data     = d;
    baud_rate   = br;
    parity_type = pt;
    stop_bits   = sb;
    tx_valid    = 1'b1;
    step();
    checks++;
    if ({tx_line, tx_ready, tx_busy} !== 3'b001) begin
      errors++;
      $display("FAIL %s_accept: line/ready/busy=%b, required 001",
               nm, {tx_line, tx_ready, tx_busy});
    end
    if (!hold) tx_valid = 1'b0;
    if (scramble) begin
      tx_data     = ~d;
      baud_rate   = ~br;
      parity_type = pt ^ 2'b10;
      stop_bits   = ~sb;
    end
  endtask

  task automatic capture(
    input string       nm,
    input int          div,
    input int          n,
    input logic [11:0] exp
  );
    int done_cnt, done_at, bad, b;
    done_cnt = 0;
    done_at  = -1;
    bad      = 0;
    for (int c = 0; c < n * div; c++) begin
      b = c / div;
      if (c % div == 0 || c % div == div - 1) begin
        checks++;
        if (tx_line !== exp[b]) begin
          errors++;
          $display("FAIL %s_bit%0d: tx_line=%b at cycle %0d, required %b",
                   nm, b, tx_line, c, exp[b]);
        end
      end
      if (tx_busy !== 1'b1 || tx_ready !== 1'b0) bad++;
      if (tx_done === 1'b1) begin
        done_cnt++;
        done_at = c;
      end
      step();
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL %s_busy: %0d cycles with wrong busy/ready, required 0",
               nm, bad);
    end
    checks++;
    if (done_cnt !== 1 || done_at !== n * div - 1) begin
      errors++;
      $display("FAIL %s_done: %0d pulses, last at %0d, required 1 at %0d",
               nm, done_cnt, done_at, n * div - 1);
    end
    checks++;
    if ({tx_line, tx_ready, tx_busy, tx_done} !== 4'b1100) begin
      errors++;
      $display("FAIL %s_end: line/ready/busy/done=%b, required 1100",
               nm, {tx_line, tx_ready, tx_busy, tx_done});
    end
  endtask

  task automatic test_reset();
    int dones, lows;
    repeat (3) step();
    checks++;
    if ({tx_line, tx_ready, tx_busy, tx_done} !== 4'b1100) begin
      errors++;
      $display("FAIL reset_state: line/ready/busy/done=%b, required 1100",
               {tx_line, tx_ready, tx_busy, tx_done});
    end
    @(negedge clock);
    reset = 1'b0;
    accept_frame("rst", 8'h55, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0);
    repeat (25) step();
    checks++;
    if (tx_line !== 1'b0) begin
      errors++;
      $display("FAIL rst_pre: tx_line=%b, required 0", tx_line);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({tx_line, tx_ready, tx_busy, tx_done} !== 4'b1100) begin
      errors++;
      $display("FAIL rst_async: line/ready/busy/done=%b, required 1100",
               {tx_line, tx_ready, tx_busy, tx_done});
    end
    @(negedge clock);
    reset = 1'b0;
    dones = 0;
    lows  = 0;
    for (int i = 0; i < 150; i++) begin
      step();
      if (tx_done === 1'b1) dones++;
      if (tx_line !== 1'b1 || tx_ready !== 1'b1) lows++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL rst_no_done: %0d tx_done pulses, required 0", dones);
    end
    checks++;
    if (lows !== 0) begin
      errors++;
      $display("FAIL rst_idle: %0d non-idle cycles, required 0", lows);
    end
  endtask

  task automatic test_basic();
    accept_frame("basic", 8'h55, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1);
    capture("basic", 10, 10, 12'b0010_1010_1010);
  endtask

  task automatic test_parity();
`ifdef UART_TX_PARITY_EN
    accept_frame("peven", 8'h07, 2'b10, 2'b10, 1'b0, 1'b0, 1'b1);
    capture("peven", 21, 11, 12'b0110_0000_1110);
    accept_frame("podd", 8'h07, 2'b10, 2'b01, 1'b0, 1'b0, 1'b1);
    capture("podd", 21, 11, 12'b0100_0000_1110);
`else
    accept_frame("peven", 8'h07, 2'b10, 2'b10, 1'b0, 1'b0, 1'b1);
    capture("peven", 21, 10, 12'b0010_0000_1110);
    accept_frame("podd", 8'h07, 2'b10, 2'b01, 1'b0, 1'b0, 1'b1);
    capture("podd", 21, 10, 12'b0010_0000_1110);
`endif
  endtask

  task automatic test_two_stop();
    accept_frame("stop2", 8'hA3, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1);
    capture("stop2", 83, 11, 12'b0111_0100_0110);
  endtask

  task automatic test_back_to_back();
    accept_frame("b2b0", 8'h11, 2'b11, 2'b00, 1'b0, 1'b1, 1'b0);
    tx_data = 8'h22;
    capture("b2b0", 10, 10, 12'b0010_0010_0010);
    step();
    checks++;
    if ({tx_line, tx_busy} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_gap: line/busy=%b one cycle after idle, required 01",
               {tx_line, tx_busy});
    end
    tx_valid = 1'b0;
    capture("b2b1", 10, 10, 12'b0010_0100_0100);
  endtask

  task automatic test_baud_change();
    accept_frame("baud0", 8'h3C, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1);
    capture("baud0", 10, 10, 12'b0010_0111_1000);
    accept_frame("baud1", 8'h3C, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    capture("baud1", 83, 10, 12'b0010_0111_1000);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_two_stop();
    test_back_to_back();
    test_baud_change();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
